pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage CPU pipeline (IF/ID/EX/MEM/WB).

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 29 ++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 23 ++
 rtl/pipeline_hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM state encoding, register-zero
// constant, pipeline action codes and the load-use compare.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [2:0] {
        ACT_IDLE   = 3'd0,
        ACT_FREEZE = 3'd1,
        ACT_STALL  = 3'd2,
        ACT_FLUSH  = 3'd3,
        ACT_RUN    = 3'd4
    } action_e;

    // A load writing r0 never creates a real dependency.
    function automatic logic load_use(input logic       memread,
                                      input logic [4:0] ex_rt,
                                      input logic [4:0] id_rs,
                                      input logic [4:0] id_rt);
        return memread && (ex_rt != REG_ZERO) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/freeze sequencer for the 5-stage pipeline. Control outputs are decoded
// combinationally from the registered state and the current hazard inputs.
//
//  state    | meaning
//  IDLE     | pipeline held, waiting for start_i
//  RUN      | normal issue; load-use stalls and branch flushes decoded here
//  MEM_WAIT | data-memory access outstanding, whole pipeline frozen
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64,
    parameter int TO_W        = 7
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rt_i,
    input  logic             id_branch_taken_i,
    input  logic             id_jump_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             pipe_freeze_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] freeze_cnt_o,
    output logic             err_o
);

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT);

    state_e          state_q, state_d;
    logic [TO_W-1:0] wait_q, wait_d;
    logic            err_q, err_d;
    action_e         act;
    logic            lu_hz;
    logic            mem_busy;

    assign lu_hz    = load_use(ex_memread_i, ex_rt_i, id_rs_i, id_rt_i);
    assign mem_busy = dmem_req_i & ~dmem_ready_i;

    // Memory freeze outranks a load-use stall, which outranks a branch flush.
    always_comb begin
        act = ACT_IDLE;
        case (state_q)
            RUN: begin
                if (mem_busy)                             act = ACT_FREEZE;
                else if (lu_hz)                           act = ACT_STALL;
                else if (id_branch_taken_i || id_jump_i)  act = ACT_FLUSH;
                else                                      act = ACT_RUN;
            end
            MEM_WAIT: act = ACT_FREEZE;
            default:  act = ACT_IDLE;
        endcase
    end

    assign pc_write_o    = (act == ACT_RUN) || (act == ACT_FLUSH);
    assign ifid_write_o  = (act == ACT_RUN) || (act == ACT_FLUSH);
    assign ifid_flush_o  = (act == ACT_FLUSH);
    assign idex_bubble_o = (act == ACT_STALL);
    assign pipe_freeze_o = (act == ACT_FREEZE) || (act == ACT_IDLE);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        err_d   = err_q;
        if (!start_i) begin
            state_d = IDLE;
            wait_d  = '0;
        end else begin
            case (state_q)
                IDLE: state_d = RUN;
                RUN:  if (mem_busy) state_d = MEM_WAIT;
                MEM_WAIT: begin
                    // Hold at the limit so the counter cannot wrap during a hung access.
                    if (wait_q != TO_LIM) wait_d = wait_q + TO_W'(1);
                    if (wait_q + TO_W'(1) == TO_LIM) err_d = 1'b1;
                    if (dmem_ready_i) begin
                        state_d = RUN;
                        wait_d  = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    assign state_o = state_q;
    assign err_o   = err_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (act == ACT_STALL),
        .count_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (act == ACT_FLUSH),
        .count_o (flush_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_freeze_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (act == ACT_FREEZE),
        .count_o (freeze_cnt_o)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized scoreboard bench: the stimulus process predicts each cycle's outputs from a
// behavioural model and queues them; the monitor checks the DUT on the falling edge.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int MT    = 4;
    localparam int TO_W  = 3;
    localparam int NCYC  = 3000;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_i, start_i;
    logic [4:0]       id_rs_i, id_rt_i, ex_rt_i;
    logic             ex_memread_i, id_branch_taken_i, id_jump_i, dmem_req_i, dmem_ready_i;
    logic             pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o, freeze_cnt_o;
    logic             err_o;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MT), .TO_W(TO_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .ex_memread_i(ex_memread_i), .ex_rt_i(ex_rt_i),
        .id_branch_taken_i(id_branch_taken_i), .id_jump_i(id_jump_i),
        .dmem_req_i(dmem_req_i), .dmem_ready_i(dmem_ready_i),
        .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .ifid_flush_o(ifid_flush_o),
        .idex_bubble_o(idex_bubble_o), .pipe_freeze_o(pipe_freeze_o), .state_o(state_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o), .freeze_cnt_o(freeze_cnt_o),
        .err_o(err_o)
    );

    typedef struct {
        int pcw, ifw, flush, bubble, freeze, st, n_stall, n_flush, n_freeze, err;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   active = 0;

    // Behavioural model: running / waiting flags, consecutive wait count, raw event totals.
    bit m_run, m_wait, m_err;
    int m_waits, m_stall, m_flush, m_freeze;

    function automatic int sat(input int n);
        return (n > MAXC) ? MAXC : n;
    endfunction

    task automatic chk(input string name, input int act, input int expv, input int cyc);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, expv);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_wait = 0; m_err = 0;
        m_waits = 0; m_stall = 0; m_flush = 0; m_freeze = 0;
    endtask

    initial begin : stim
        exp_t e;
        bit lu, busy, do_freeze, do_stall, do_flush;
        rst_i = 1'b1; start_i = 1'b1;
        id_rs_i = '0; id_rt_i = '0; ex_rt_i = '0; ex_memread_i = 1'b0;
        id_branch_taken_i = 1'b0; id_jump_i = 1'b0; dmem_req_i = 1'b0; dmem_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        active = 1;
        for (int n = 0; n < NCYC; n++) begin
            #1;
            rst_i             = ($urandom_range(0, 149) == 0);
            start_i           = ($urandom_range(0, 39) != 0);
            ex_memread_i      = ($urandom_range(0, 1) == 1);
            ex_rt_i           = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            id_rs_i           = 5'($urandom_range(0, 3));
            id_rt_i           = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            id_branch_taken_i = ($urandom_range(0, 3) == 0);
            id_jump_i         = ($urandom_range(0, 5) == 0);
            dmem_req_i        = ($urandom_range(0, 3) == 0);
            dmem_ready_i      = m_wait ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 1);
            // Periodic burst of back-to-back load-use stalls to drive the counters into saturation.
            if ((n % 500) >= 200 && (n % 500) < 260) begin
                rst_i = 1'b0; start_i = 1'b1; dmem_req_i = 1'b0;
                ex_memread_i = 1'b1; ex_rt_i = 5'd8; id_rs_i = 5'd8;
            end

            lu   = ex_memread_i && (ex_rt_i != 0) && (ex_rt_i == id_rs_i || ex_rt_i == id_rt_i);
            busy = dmem_req_i && !dmem_ready_i;
            do_freeze = m_run && (m_wait || busy);
            do_stall  = m_run && !do_freeze && lu;
            do_flush  = m_run && !do_freeze && !lu && (id_branch_taken_i || id_jump_i);

            e.pcw      = (m_run && !do_freeze && !do_stall) ? 1 : 0;
            e.ifw      = e.pcw;
            e.flush    = do_flush ? 1 : 0;
            e.bubble   = do_stall ? 1 : 0;
            e.freeze   = (!m_run || do_freeze) ? 1 : 0;
            e.st       = !m_run ? 0 : (m_wait ? 2 : 1);
            e.n_stall  = sat(m_stall);
            e.n_flush  = sat(m_flush);
            e.n_freeze = sat(m_freeze);
            e.err      = m_err ? 1 : 0;
            exp_q.push_back(e);

            if (rst_i) begin
                model_reset();
            end else begin
                if (do_freeze) m_freeze++;
                if (do_stall)  m_stall++;
                if (do_flush)  m_flush++;
                if (!start_i) begin
                    m_run = 0; m_wait = 0; m_waits = 0;
                end else if (!m_run) begin
                    m_run = 1;
                end else if (m_wait) begin
                    m_waits++;
                    if (m_waits >= MT) m_err = 1;
                    if (dmem_ready_i) begin
                        m_wait = 0; m_waits = 0;
                    end
                end else if (busy) begin
                    m_wait = 1;
                end
            end
            @(posedge clk);
        end
        active = 0;
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_expectations got=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : monitor
        exp_t e;
        int   cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (active) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard_empty cycle=%0d got=0 expected=1", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("pc_write",   int'(pc_write_o),    e.pcw,      cyc);
                    chk("ifid_write", int'(ifid_write_o),  e.ifw,      cyc);
                    chk("ifid_flush", int'(ifid_flush_o),  e.flush,    cyc);
                    chk("idex_bubble", int'(idex_bubble_o), e.bubble,  cyc);
                    chk("pipe_freeze", int'(pipe_freeze_o), e.freeze,  cyc);
                    chk("state",      int'(state_o),       e.st,       cyc);
                    chk("stall_cnt",  int'(stall_cnt_o),   e.n_stall,  cyc);
                    chk("flush_cnt",  int'(flush_cnt_o),   e.n_flush,  cyc);
                    chk("freeze_cnt", int'(freeze_cnt_o),  e.n_freeze, cyc);
                    chk("err",        int'(err_o),         e.err,      cyc);
                end
                cyc++;
            end
        end
    end

endmodule
